// File: rtl/fft_frame_ctrl.sv
// Moves a 1024-bit SPI frame into the FFT sample memory, runs the FFT and packs the result bins.
// Build option FFT_MAG_EN: bins become saturated |re|+|im| instead of the raw real part.
module fft_frame_ctrl #(
   parameter int N_SAMPLES = 64,
   parameter int SAMPLE_W  = 16
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [N_SAMPLES*SAMPLE_W-1:0]   frame_in,
   input  logic                            frame_valid,
   output logic                            mem_we,
   output logic [$clog2(N_SAMPLES)-1:0]    mem_addr,
   output logic [2*SAMPLE_W-1:0]           mem_wdata,
   input  logic [2*SAMPLE_W-1:0]           mem_rdata,
   output logic                            fft_start,
   input  logic                            fft_done,
   output logic [N_SAMPLES*SAMPLE_W-1:0]   frame_out,
   output logic                            out_valid,
   output logic                            busy,
   output logic                            overrun
);

   localparam int ADDR_W = $clog2(N_SAMPLES);
   localparam int CNT_W  = ADDR_W + 1;
   localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(N_SAMPLES - 1);
   localparam logic [CNT_W-1:0]  LOAD_LAST = CNT_W'(N_SAMPLES - 1);
   localparam logic [CNT_W-1:0]  READ_LAST = CNT_W'(N_SAMPLES);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_START = 3'd2,
      S_WAIT  = 3'd3,
      S_READ  = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t                             state_r, state_next_s;
   logic [CNT_W-1:0]                   cnt_r, cnt_next_s;
   logic                               sync1_r, sync2_r, sync3_r;
   logic                               rise_s;
   logic [N_SAMPLES-1:0][SAMPLE_W-1:0] frame_buf_r;
   logic [N_SAMPLES-1:0][SAMPLE_W-1:0] shadow_r;
   logic [N_SAMPLES-1:0][SAMPLE_W-1:0] frame_out_r;
   logic [ADDR_W-1:0]                  rd_idx_s;
   logic [SAMPLE_W-1:0]                bin_s;
   logic                               overrun_r;

`ifdef FFT_MAG_EN
   function automatic logic [SAMPLE_W:0] abs_ext(input logic [SAMPLE_W-1:0] v);
      logic [SAMPLE_W:0] ext;
      ext = {v[SAMPLE_W-1], v};
      abs_ext = v[SAMPLE_W-1] ? (~ext + {{SAMPLE_W{1'b0}}, 1'b1}) : ext;
   endfunction

   // |re|+|im| needs one extra bit only for the -max/-max corner, which saturates
   function automatic logic [SAMPLE_W-1:0] bin_value(input logic [2*SAMPLE_W-1:0] word);
      logic [SAMPLE_W:0] mag;
      mag = abs_ext(word[SAMPLE_W-1:0]) + abs_ext(word[2*SAMPLE_W-1:SAMPLE_W]);
      bin_value = mag[SAMPLE_W] ? {SAMPLE_W{1'b1}} : mag[SAMPLE_W-1:0];
   endfunction

   assign bin_s = bin_value(mem_rdata);
`else
   logic imag_unused_s;

   function automatic logic [SAMPLE_W-1:0] bin_value(input logic [SAMPLE_W-1:0] re);
      bin_value = re;
   endfunction

   assign bin_s         = bin_value(mem_rdata[SAMPLE_W-1:0]);
   assign imag_unused_s = ^mem_rdata[2*SAMPLE_W-1:SAMPLE_W];
`endif

   assign rise_s    = sync2_r & ~sync3_r;
   assign rd_idx_s  = cnt_r[ADDR_W-1:0] - {{(ADDR_W-1){1'b0}}, 1'b1};
   assign frame_out = frame_out_r;
   assign overrun   = overrun_r;

   // State and sequence counter register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= S_IDLE;
         cnt_r   <= {CNT_W{1'b0}};
      end else begin
         state_r <= state_next_s;
         cnt_r   <= cnt_next_s;
      end
   end

   // Next-state and counter sequencing
   always_comb begin
      state_next_s = state_r;
      cnt_next_s   = cnt_r;
      case (state_r)
         S_IDLE: begin
            if (rise_s) begin
               state_next_s = S_LOAD;
               cnt_next_s   = {CNT_W{1'b0}};
            end else begin
               state_next_s = S_IDLE;
            end
         end
         S_LOAD: begin
            if (cnt_r == LOAD_LAST) begin
               state_next_s = S_START;
               cnt_next_s   = {CNT_W{1'b0}};
            end else begin
               cnt_next_s   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
         S_START: state_next_s = S_WAIT;
         S_WAIT: begin
            if (fft_done) begin
               state_next_s = S_READ;
               cnt_next_s   = {CNT_W{1'b0}};
            end else begin
               state_next_s = S_WAIT;
            end
         end
         // READ runs one count past the last address to take the final capture
         S_READ: begin
            if (cnt_r == READ_LAST) begin
               state_next_s = S_DONE;
               cnt_next_s   = {CNT_W{1'b0}};
            end else begin
               cnt_next_s   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
         S_DONE: state_next_s = S_IDLE;
         default: begin
            state_next_s = S_IDLE;
            cnt_next_s   = {CNT_W{1'b0}};
         end
      endcase
   end

   // Output decode from the registered state and counter
   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = {ADDR_W{1'b0}};
      mem_wdata = {(2*SAMPLE_W){1'b0}};
      fft_start = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      case (state_r)
         S_IDLE: busy = 1'b0;
         S_LOAD: begin
            mem_we    = 1'b1;
            mem_addr  = cnt_r[ADDR_W-1:0];
            mem_wdata = {{SAMPLE_W{1'b0}}, frame_buf_r[LAST_IDX - cnt_r[ADDR_W-1:0]]};
         end
         S_START: fft_start = 1'b1;
         S_WAIT:  busy      = 1'b1;
         S_READ: begin
            if (cnt_r == READ_LAST) begin
               mem_addr = LAST_IDX;
            end else begin
               mem_addr = cnt_r[ADDR_W-1:0];
            end
         end
         S_DONE:  out_valid = 1'b1;
         default: busy      = 1'b0;
      endcase
   end

   // Frame sync, capture, bin collection and atomic result publish
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_r     <= 1'b0;
         sync2_r     <= 1'b0;
         sync3_r     <= 1'b0;
         overrun_r   <= 1'b0;
         frame_buf_r <= {(N_SAMPLES*SAMPLE_W){1'b0}};
         shadow_r    <= {(N_SAMPLES*SAMPLE_W){1'b0}};
         frame_out_r <= {(N_SAMPLES*SAMPLE_W){1'b0}};
      end else begin
         sync1_r <= frame_valid;
         sync2_r <= sync1_r;
         sync3_r <= sync2_r;
         if (rise_s) begin
            if (state_r == S_IDLE) begin
               frame_buf_r <= frame_in;
            end else begin
               overrun_r <= 1'b1;
            end
         end
         if (state_r == S_READ && cnt_r != {CNT_W{1'b0}}) begin
            shadow_r[LAST_IDX - rd_idx_s] <= bin_s;
         end
         // The final bin is merged directly so frame_out is complete when DONE is entered
         if (state_r == S_READ && cnt_r == READ_LAST) begin
            frame_out_r <= {shadow_r[N_SAMPLES-1:1], bin_s};
         end
      end
   end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl with a sample-memory / FFT responder model.
module tb_fft_frame_ctrl;

   localparam int N  = 64;
   localparam int FW = 1024;

   logic          clk = 1'b0;
   logic          reset;
   logic [FW-1:0] frame_in;
   logic          frame_valid;
   logic          mem_we;
   logic [5:0]    mem_addr;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata = 32'h0;
   logic          fft_start;
   logic          fft_done;
   logic [FW-1:0] frame_out;
   logic          out_valid;
   logic          busy;
   logic          overrun;

   int total = 0;
   int bad   = 0;
   int wr_cnt = 0, start_cnt = 0, ov_cnt = 0;
   logic [5:0]  wr_addr_log [0:1023];
   logic [31:0] wr_data_log [0:1023];
   logic [15:0] bin_ofs = 16'h0000;

   fft_frame_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .frame_in   (frame_in),
      .frame_valid(frame_valid),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .fft_start  (fft_start),
      .fft_done   (fft_done),
      .frame_out  (frame_out),
      .out_valid  (out_valid),
      .busy       (busy),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] bin_word(input logic [5:0] a);
      case (a)
         6'd5:    bin_word = 32'h8000_8000;
         6'd6:    bin_word = 32'h0004_FFFD;
         default: bin_word = {16'h0000, {10'b0, a} + bin_ofs};
      endcase
   endfunction

   // Memory/FFT responder: 1-clk read latency, write and pulse logging
   always @(posedge clk) begin
      mem_rdata <= bin_word(mem_addr);
      if (mem_we && wr_cnt < 1024) begin
         wr_addr_log[wr_cnt] <= mem_addr;
         wr_data_log[wr_cnt] <= mem_wdata;
      end
      if (mem_we)    wr_cnt    <= wr_cnt + 1;
      if (fft_start) start_cnt <= start_cnt + 1;
      if (out_valid) ov_cnt    <= ov_cnt + 1;
   end

   function automatic logic [15:0] samp(input int pat, input int i);
      samp = (pat == 0) ? 16'(i + 1) : (16'hF000 | 16'(i));
   endfunction

   function automatic logic [FW-1:0] mk_frame(input int pat);
      logic [FW-1:0] f;
      f = '0;
      for (int i = 0; i < N; i++) f[FW-1-16*i -: 16] = samp(pat, i);
      mk_frame = f;
   endfunction

   function automatic logic [15:0] exp_field(input int k, input logic [15:0] ofs);
`ifdef FFT_MAG_EN
      if (k == 5)      exp_field = 16'hFFFF;
      else if (k == 6) exp_field = 16'h0007;
      else             exp_field = 16'(k) + ofs;
`else
      if (k == 5)      exp_field = 16'h8000;
      else if (k == 6) exp_field = 16'hFFFD;
      else             exp_field = 16'(k) + ofs;
`endif
   endfunction

   function automatic logic [FW-1:0] exp_frame(input logic [15:0] ofs);
      logic [FW-1:0] f;
      f = '0;
      for (int k = 0; k < N; k++) f[FW-1-16*k -: 16] = exp_field(k, ofs);
      exp_frame = f;
   endfunction

   function automatic logic sig(input int which);
      case (which)
         0:       sig = busy;
         1:       sig = fft_start;
         2:       sig = out_valid;
         3:       sig = mem_we && mem_addr == 6'd20;
         4:       sig = mem_we && mem_addr == 6'd10;
         default: sig = 1'b0;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_for(input int which, input int limit, output int n);
      n = 0;
      while (!sig(which) && n < limit) begin
         tick();
         n++;
      end
   endtask

   task automatic check_frame(input string tag, input logic [15:0] ofs);
      for (int k = 0; k < N; k++)
         check($sformatf("%s[%0d]", tag, k), {16'h0, frame_out[FW-1-16*k -: 16]},
               {16'h0, exp_field(k, ofs)});
   endtask

   task automatic check_writes(input string tag, input int base, input int pat);
      for (int i = 0; i < N; i++) begin
         check($sformatf("%s_addr[%0d]", tag, i), {26'h0, wr_addr_log[base+i]}, 32'(i));
         check($sformatf("%s_data[%0d]", tag, i), wr_data_log[base+i], {16'h0, samp(pat, i)});
      end
   endtask

   initial begin
      int n, held, early, wr_base, st_base, ov_base;
      logic [FW-1:0] exp_old;
      reset = 1'b1; frame_valid = 1'b0; fft_done = 1'b0; frame_in = '0;
      repeat (3) tick();
      check("rst_busy", {31'h0, busy}, 32'h0);
      check("rst_we", {31'h0, mem_we}, 32'h0);
      check("rst_start", {31'h0, fft_start}, 32'h0);
      check("rst_out_valid", {31'h0, out_valid}, 32'h0);
      check("rst_overrun", {31'h0, overrun}, 32'h0);
      check("rst_addr", {26'h0, mem_addr}, 32'h0);
      check("rst_wdata", mem_wdata, 32'h0);
      check("rst_frame_out", {31'h0, |frame_out}, 32'h0);
      reset = 1'b0;
      repeat (2) tick();

      // Ramp frame
      frame_in = mk_frame(0);
      frame_valid = 1'b1;
      wait_for(0, 10, n);
      check("busy_lat_ok", {31'h0, (n >= 3 && n <= 4)}, 32'h1);
      check("load0_we", {31'h0, mem_we}, 32'h1);
      check("load0_addr", {26'h0, mem_addr}, 32'h0);
      check("load0_wdata", mem_wdata, 32'h0000_0001);
      wait_for(1, 100, n);
      check("start_lat", 32'(n), 32'd64);
      check("start_high", {31'h0, fft_start}, 32'h1);
      tick();
      check("start_width", {31'h0, fft_start}, 32'h0);
      check("wait_busy", {31'h0, busy}, 32'h1);
      check("ramp_wr_cnt", 32'(wr_cnt), 32'd64);
      check("ramp_start_cnt", 32'(start_cnt), 32'd1);
      check_writes("ramp", 0, 0);

      // Second edge during WAIT is dropped
      frame_valid = 1'b0;
      repeat (4) tick();
      frame_valid = 1'b1;
      repeat (4) tick();
      check("overrun_set", {31'h0, overrun}, 32'h1);
      check("overrun_busy", {31'h0, busy}, 32'h1);
      check("overrun_no_wr", 32'(wr_cnt), 32'd64);

      fft_done = 1'b1;
      tick();
      fft_done = 1'b0;
      check("read0_we", {31'h0, mem_we}, 32'h0);
      check("read0_addr", {26'h0, mem_addr}, 32'h0);
      n = 1;
      while (!out_valid && n < 150) begin tick(); n++; end
      check("done_lat", 32'(n), 32'd66);
      check("done_busy", {31'h0, busy}, 32'h1);
      check_frame("ramp_bins", 16'h0000);
      tick();
      check("out_valid_width", {31'h0, out_valid}, 32'h0);
      check("idle_after_done", {31'h0, busy}, 32'h0);
      check("ramp_ov_cnt", 32'(ov_cnt), 32'd1);
      check("ramp_read_no_wr", 32'(wr_cnt), 32'd64);
      repeat (10) tick();
      check("no_retrigger_busy", {31'h0, busy}, 32'h0);
      check("no_retrigger_start", 32'(start_cnt), 32'd1);
      check("overrun_sticky", {31'h0, overrun}, 32'h1);

      // Reset in the middle of LOAD
      frame_valid = 1'b0;
      repeat (4) tick();
      frame_in = mk_frame(1);
      frame_valid = 1'b1;
      wait_for(3, 100, n);
      check("w20_seen", {31'h0, sig(3)}, 32'h1);
      check("w20_wdata", mem_wdata, 32'h0000_F014);
      reset = 1'b1;
      frame_valid = 1'b0;
      tick();
      check("mrst_we", {31'h0, mem_we}, 32'h0);
      check("mrst_addr", {26'h0, mem_addr}, 32'h0);
      check("mrst_wdata", mem_wdata, 32'h0);
      check("mrst_busy", {31'h0, busy}, 32'h0);
      check("mrst_start", {31'h0, fft_start}, 32'h0);
      check("mrst_out_valid", {31'h0, out_valid}, 32'h0);
      check("mrst_overrun", {31'h0, overrun}, 32'h0);
      check("mrst_frame_out", {31'h0, |frame_out}, 32'h0);
      reset = 1'b0;
      repeat (4) tick();
      check("mrst_idle", {31'h0, busy}, 32'h0);

      // Held level for 500 clk with an early fft_done during LOAD
      wr_base = wr_cnt; st_base = start_cnt; ov_base = ov_cnt;
      bin_ofs = 16'h0100;
      frame_valid = 1'b1;
      held = 0;
      wait_for(0, 10, n); held += n;
      check("p2_busy", {31'h0, busy}, 32'h1);
      wait_for(4, 100, n); held += n;
      fft_done = 1'b1;
      tick(); held++;
      fft_done = 1'b0;
      wait_for(1, 100, n); held += n;
      check("p2_start_seen", {31'h0, fft_start}, 32'h1);
      check("p2_no_early_start", 32'(start_cnt - st_base), 32'd0);
      repeat (20) tick();
      held += 20;
      check("p2_early_done_ignored", {31'h0, busy}, 32'h1);
      check("p2_no_out", 32'(ov_cnt - ov_base), 32'd0);
      check("p2_wr_cnt", 32'(wr_cnt - wr_base), 32'd64);
      check_writes("p2", wr_base, 1);
      fft_done = 1'b1;
      tick(); held++;
      fft_done = 1'b0;
      n = 1; early = 0;
      while (!out_valid && n < 150) begin
         if (frame_out !== '0) early++;
         tick(); n++;
      end
      held += n;
      check("p2_hold_old", 32'(early), 32'd0);
      check("p2_done_lat", 32'(n), 32'd66);
      check_frame("p2_bins", 16'h0100);
      while (held < 500) begin tick(); held++; end
      check("p2_one_start", 32'(start_cnt - st_base), 32'd1);
      check("p2_one_out", 32'(ov_cnt - ov_base), 32'd1);
      check("p2_one_pass_wr", 32'(wr_cnt - wr_base), 32'd64);
      check("p2_idle", {31'h0, busy}, 32'h0);
      check("p2_no_overrun", {31'h0, overrun}, 32'h0);

      // frame_out stability across a third frame
      frame_valid = 1'b0;
      repeat (4) tick();
      frame_in = mk_frame(0);
      bin_ofs = 16'h0200;
      frame_valid = 1'b1;
      wait_for(1, 120, n);
      check("p3_start_seen", {31'h0, fft_start}, 32'h1);
      tick();
      fft_done = 1'b1;
      tick();
      fft_done = 1'b0;
      exp_old = exp_frame(16'h0100);
      n = 1; early = 0;
      while (!out_valid && n < 150) begin
         if (frame_out !== exp_old) early++;
         tick(); n++;
      end
      check("p3_hold_old", 32'(early), 32'd0);
      check("p3_done_lat", 32'(n), 32'd66);
      check_frame("p3_bins", 16'h0200);
      tick();
      check("p3_kept", {16'h0, frame_out[FW-1 -: 16]}, 32'h0000_0200);
      check("p3_idle", {31'h0, busy}, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fft_frame_ctrl.md
# fft_frame_ctrl

Sequencer between the 1024-bit SPI frame receiver and the FFT core. It takes a completed SPI frame from the `sck` domain into the system clock domain and unpacks it into 64 16-bit samples. It writes them into the FFT sample memory, starts the FFT and waits for completion, then reads the 64 result bins back. Each bin is packed into a 16-bit field of a 1024-bit result word, which the SPI block shifts out on the next transfer.

## Interface
- `N_SAMPLES`, 64, number of samples/bins per frame; frame width = N_SAMPLES*SAMPLE_W = 1024
- `SAMPLE_W`, 16, bits per sample and per output bin
- `clk  in  1  system clock`
- `reset  in  1  synchronous, active-high`
- `frame_in  in  1024  frame from SPI receiver; stable while frame_valid high`
- `frame_valid  in  1  level from SPI domain (asynchronous); high when a full frame is held`
- `mem_we  out  1  sample memory write enable`
- `mem_addr  out  6  sample memory address (shared write/read)`
- `mem_wdata  out  32  {imag[15:0], real[15:0]}; imag always 0`
- `mem_rdata  in  32  {imag, real} of bin; valid 1 clk after mem_addr`
- `fft_start  out  1  one-cycle start pulse to FFT core`
- `fft_done  in  1  FFT complete; sampled level, only honoured in WAIT`
- `frame_out  out  1024  packed result bins to SPI transmitter`
- `out_valid  out  1  one-cycle pulse when frame_out updates`
- `busy  out  1  high in every state except IDLE`
- `overrun  out  1  sticky: a frame arrived while busy`

## Operation
- Sync: frame_valid -> 2 flops -> rising-edge detect on the synchronised level. Edge in IDLE: capture frame_in into the local `frame_buf` and go to LOAD.
- Sample order is MSB-first, matching SPI bit order. Sample i = frame_buf[1023-16i -: 16], for i = 0..63.
- States: IDLE, LOAD, START, WAIT, READ, DONE.
- LOAD: one write per clk. mem_addr = i, mem_wdata = {16'h0, sample i}, mem_we = 1, i = 0..63. After i=63, go to START.
- START: fft_start = 1 for exactly one clk, then go to WAIT.
- WAIT: hold until fft_done = 1, then go to READ. There is no timeout.
- READ: issue mem_addr k = 0..63 on consecutive clks with mem_we = 0. Capture mem_rdata for bin k one clk later into shadow field shadow[1023-16k -: 16]. The last capture happens one clk after addr 63 is issued; then go to DONE.
- DONE: frame_out <= shadow in a single atomic update, out_valid = 1, return to IDLE.
- frame_out changes only in DONE and never mid-frame.
- Edge detected while busy: frame dropped, overrun <= 1, state unaffected. overrun clears only on reset.
- A frame_valid level held high does not retrigger. A new frame requires a fall and a rise.
- Reset, including mid-operation:
  - state IDLE, counters 0, sync flops 0.
  - mem_we, fft_start, out_valid, busy, overrun all 0.
  - mem_addr 0, mem_wdata 0, frame_out 0, shadow 0.

## Timing
- frame_valid rises: edge detected 2–3 clk later (cycle E), frame captured at E.
- LOAD writes occupy E+1..E+64.
- fft_start is high at E+65.
- READ addresses are issued from D+1 to D+64, where D is the cycle fft_done is seen in WAIT. The last capture is at D+65.
- DONE, with out_valid and the new frame_out, is at D+66.
- busy is high from E+1 through DONE inclusive. IDLE is re-entered at D+67.
- fft_done asserted before WAIT is ignored.

## Configuration
- `FFT_MAG_EN` defined: bin value = |re| + |im|, computed 17-bit unsigned and saturated to 16'hFFFF. |−32768| = 32768.
- `FFT_MAG_EN` undefined: bin value = re (mem_rdata[15:0]) as raw two's complement; imag is ignored.
- Latency is identical in both builds.

## Test plan
- Ramp: frame with sample i = i+1. Expect 64 writes, addr 0..63, wdata 32'h0000_0001..32'h0000_0040, then one fft_start pulse. A bench FFT model returns bin k = {16'h0, k}. Expect frame_out field k = k, out_valid for one clk, busy low after.
- Magnitude: bin 5 returns re = 16'h8000, im = 16'h8000. Expect field 5 = 16'hFFFF with FFT_MAG_EN and 16'h8000 without. Bin 6 re = −3, im = 4 gives 16'h0007 with the macro.
- Overrun: raise frame_valid again during WAIT. Expect overrun = 1, no extra writes, and the first frame completes normally.
- Reset mid-LOAD: assert reset at write 20. Expect all outputs 0 next clk. A new frame then starts cleanly from addr 0.
- Held level / early done: hold frame_valid high for 500 clk and pulse fft_done during LOAD. Expect exactly one processing pass, and fft_start precedes the READ phase.
- frame_out stability: across a second frame, frame_out keeps its previous value until DONE, then changes in one clk.
